led_pio_arbiter: RTL and testbench

LED_PIO_ARBITER -- requirements
Module: led_pio_arbiter

---
 rtl/led_pio_pkg.sv | 19 +
 rtl/led_rr_arb2.sv | 25 ++
 rtl/led_pio_arbiter.sv | 153 +++++++++++++++
 tb/tb_led_pio_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/led_pio_pkg.sv
// Shared types and constants for the LED PIO arbiter.
package led_pio_pkg;

  localparam int unsigned LED_W_DEFAULT = 14;
  localparam logic [1:0]  PIO_ADDR_DATA = 2'd0;

  typedef logic [23:0] hold_cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    FL_ON,
    HOLD_ON,
    FL_OFF,
    HOLD_OFF,
    RESTORE
  } state_t;

endpackage

// File: rtl/led_rr_arb2.sv
// Two-way round-robin arbiter with a one-hot grant.
module led_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       update,
  output logic [1:0] grant
);

  logic prio_b;

  always_comb begin
    grant = 2'b00;
    if (req_a && (!req_b || !prio_b)) grant = 2'b01;
    else if (req_b)                   grant = 2'b10;
  end

  // Priority only moves on contention: an uncontested grant leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         prio_b <= 1'b0;
    else if (update && req_a && req_b)    prio_b <= grant[0];
  end

endmodule

// File: rtl/led_pio_arbiter.sv
// Arbitrates status (A) and line-clear flash (B) LED requests onto one PIO.
// Define LED_PIO_ARBITER_FLASH_EN to build the B flash sequencer.
module led_pio_arbiter
  import led_pio_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 5000000,
  parameter int unsigned LED_W       = LED_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_a,
  input  logic [LED_W-1:0] data_a,
  input  logic             req_b,
  input  logic [LED_W-1:0] data_b,
  input  logic [2:0]       flash_cnt_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             busy,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata
);

  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 32'h00FF_FFFF || LED_W > 32) begin : g_param_chk
    $error("led_pio_arbiter: HOLD_CYCLES or LED_W out of range");
  end

  state_t           state;
  logic [LED_W-1:0] shadow;
  logic [1:0]       grant;
  logic             arb_upd;

  assign arb_upd     = (state == IDLE) && (req_a || req_b);
  assign busy        = (state != IDLE);
  assign avm_address = PIO_ADDR_DATA;

  led_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_a   (req_a),
    .req_b   (req_b),
    .update  (arb_upd),
    .grant   (grant)
  );

  function automatic logic [31:0] pio_word(input logic [LED_W-1:0] p);
    return 32'(p);
  endfunction

`ifdef LED_PIO_ARBITER_FLASH_EN
  localparam hold_cnt_t HOLD_LAST = hold_cnt_t'(HOLD_CYCLES - 2);

  logic [LED_W-1:0] pattern;
  logic [2:0]       pairs;
  hold_cnt_t        hold_cnt;
  logic             hold_done;

  assign hold_done = (hold_cnt == HOLD_LAST);
`else
  wire unused_flash_cnt = ^flash_cnt_b;
`endif

  // Outputs are registered on the edge that enters a write state, so the
  // write appears during that state's single cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      shadow         <= '0;
      ack_a          <= 1'b0;
      ack_b          <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
`ifdef LED_PIO_ARBITER_FLASH_EN
      pattern        <= '0;
      pairs          <= '0;
      hold_cnt       <= '0;
`endif
    end else begin
      ack_a          <= 1'b0;
      ack_b          <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      case (state)
        IDLE: begin
          if (grant[0]) begin
            state          <= WR_A;
            shadow         <= data_a;
            ack_a          <= 1'b1;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_writedata  <= pio_word(data_a);
          end else if (grant[1]) begin
`ifdef LED_PIO_ARBITER_FLASH_EN
            state          <= FL_ON;
            pattern        <= data_b;
            pairs          <= (flash_cnt_b == 3'd0) ? 3'd1 : flash_cnt_b;
`else
            state          <= WR_A;
            shadow         <= data_b;
            ack_b          <= 1'b1;
`endif
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_writedata  <= pio_word(data_b);
          end
        end
        WR_A: state <= IDLE;
`ifdef LED_PIO_ARBITER_FLASH_EN
        FL_ON: begin
          state    <= HOLD_ON;
          hold_cnt <= '0;
        end
        HOLD_ON: begin
          if (hold_done) begin
            state          <= FL_OFF;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 24'd1;
          end
        end
        FL_OFF: begin
          state    <= HOLD_OFF;
          hold_cnt <= '0;
          pairs    <= pairs - 3'd1;
        end
        HOLD_OFF: begin
          if (hold_done) begin
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            if (pairs != 3'd0) begin
              state         <= FL_ON;
              avm_writedata <= pio_word(pattern);
            end else begin
              state         <= RESTORE;
              ack_b         <= 1'b1;
              avm_writedata <= pio_word(shadow);
            end
          end else begin
            hold_cnt <= hold_cnt + 24'd1;
          end
        end
        RESTORE: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Directed bench for led_pio_arbiter; covers the flash build when
// LED_PIO_ARBITER_FLASH_EN is defined.
module tb_led_pio_arbiter;

  localparam int H = 4;
  localparam int W = 14;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic [W-1:0]  data_a = '0, data_b = '0;
  logic [2:0]    flash_cnt_b = '0;
  logic          ack_a, ack_b, busy, avm_chipselect, avm_write_n;
  logic [1:0]    avm_address;
  logic [31:0]   avm_writedata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_pio_arbiter #(.HOLD_CYCLES(H), .LED_W(W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_a          (req_a),
    .data_a         (data_a),
    .req_b          (req_b),
    .data_b         (data_b),
    .flash_cnt_b    (flash_cnt_b),
    .ack_a          (ack_a),
    .ack_b          (ack_b),
    .busy           (busy),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata)
  );

  task automatic test_reset;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({ack_a, ack_b} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {ack_a, ack_b}); end
    checks++; if ({avm_chipselect, avm_write_n} !== 2'b01) begin errors++; $display("FAIL reset_strobes: got %b want 01", {avm_chipselect, avm_write_n}); end
    checks++; if (avm_writedata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", avm_writedata); end
    checks++; if (avm_address !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", avm_address); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_a;
    req_a = 1'b1; data_a = 14'h0155;
    @(negedge clk);
    checks++; if ({avm_chipselect, avm_write_n} !== 2'b10) begin errors++; $display("FAIL a_strobe: got %b want 10", {avm_chipselect, avm_write_n}); end
    checks++; if (avm_writedata !== 32'h0000_0155) begin errors++; $display("FAIL a_wdata: got %h want 00000155", avm_writedata); end
    checks++; if ({ack_a, ack_b} !== 2'b10) begin errors++; $display("FAIL a_ack: got %b want 10", {ack_a, ack_b}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL a_busy: got %b want 1", busy); end
    checks++; if (avm_address !== 2'd0) begin errors++; $display("FAIL a_addr: got %0d want 0", avm_address); end
    req_a = 1'b0;
    @(negedge clk);
    checks++; if ({avm_chipselect, ack_a, busy} !== 3'b000) begin errors++; $display("FAIL a_after: got %b want 000", {avm_chipselect, ack_a, busy}); end
  endtask

  task automatic test_round_robin(input logic want_b_first, input string nm);
    logic first_b;
    int   n;
    first_b = 1'bx; n = 0;
    req_a = 1'b1; data_a = 14'h00F0; req_b = 1'b1; data_b = 14'h0AAA; flash_cnt_b = 3'd1;
    for (int c = 0; c < 60 && (req_a || req_b); c++) begin
      @(negedge clk);
      checks++; if (ack_a && ack_b) begin errors++; $display("FAIL %s_dual_ack: got 11 want at most one", nm); end
      if (ack_a || ack_b) begin
        if (n == 0) first_b = ack_b;
        n++;
      end
      if (ack_a) req_a = 1'b0;
      if (ack_b) req_b = 1'b0;
    end
    req_a = 1'b0; req_b = 1'b0;
    checks++; if (n !== 2) begin errors++; $display("FAIL %s_ack_count: got %0d want 2", nm, n); end
    checks++; if (first_b !== want_b_first) begin errors++; $display("FAIL %s_first: got b_first=%b want %b", nm, first_b, want_b_first); end
    @(negedge clk);
  endtask

`ifdef LED_PIO_ARBITER_FLASH_EN
  // Writes at offsets 1+4j; pattern/0 alternating, restore of shadow last.
  task automatic test_flash_pairs(input logic [2:0] cnt, input logic [W-1:0] pat,
                                  input int npairs, input logic [31:0] shadow_exp, input string nm);
    int          last;
    logic        exp_w;
    logic [31:0] exp_d;
    last = 8 * npairs + 1;
    req_b = 1'b1; data_b = pat; flash_cnt_b = cnt;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      exp_w = (k % 4 == 1);
      if (k == last)             exp_d = shadow_exp;
      else if (((k - 1) / 4) % 2 == 0) exp_d = 32'(pat);
      else                       exp_d = 32'h0;
      checks++; if ({avm_chipselect, avm_write_n} !== {exp_w, ~exp_w}) begin errors++; $display("FAIL %s_strobe@%0d: got %b want %b", nm, k, {avm_chipselect, avm_write_n}, {exp_w, ~exp_w}); end
      if (exp_w) begin
        checks++; if (avm_writedata !== exp_d) begin errors++; $display("FAIL %s_wdata@%0d: got %h want %h", nm, k, avm_writedata, exp_d); end
      end
      checks++; if (ack_b !== (k == last)) begin errors++; $display("FAIL %s_ack_b@%0d: got %b want %b", nm, k, ack_b, (k == last)); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy@%0d: got %b want 1", nm, k, busy); end
      if (ack_b) req_b = 1'b0;
    end
    req_b = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle: got busy=%b want 0", nm, busy); end
  endtask

  task automatic test_reset_mid;
    int n;
    req_b = 1'b1; data_b = 14'h1111; flash_cnt_b = 3'd2;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    req_b = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if ({avm_chipselect, avm_write_n, ack_b} !== 3'b010) begin errors++; $display("FAIL mid_outputs: got %b want 010", {avm_chipselect, avm_write_n, ack_b}); end
    checks++; if (avm_writedata !== 32'h0) begin errors++; $display("FAIL mid_wdata: got %h want 0", avm_writedata); end
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (avm_chipselect || ack_b) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL mid_no_activity: got %0d events want 0", n); end
  endtask
`else
  task automatic test_b_single;
    req_b = 1'b1; data_b = 14'h2AAA; flash_cnt_b = 3'd3;
    @(negedge clk);
    checks++; if ({avm_chipselect, avm_write_n} !== 2'b10) begin errors++; $display("FAIL b_strobe: got %b want 10", {avm_chipselect, avm_write_n}); end
    checks++; if (avm_writedata !== 32'h0000_2AAA) begin errors++; $display("FAIL b_wdata: got %h want 00002aaa", avm_writedata); end
    checks++; if ({ack_a, ack_b} !== 2'b01) begin errors++; $display("FAIL b_ack: got %b want 01", {ack_a, ack_b}); end
    req_b = 1'b0;
    @(negedge clk);
    checks++; if ({avm_chipselect, ack_b, busy} !== 3'b000) begin errors++; $display("FAIL b_after: got %b want 000", {avm_chipselect, ack_b, busy}); end
  endtask
`endif

  initial begin
    test_reset;
    test_write_a;
    test_round_robin(1'b0, "rr1");
    test_round_robin(1'b1, "rr2");
`ifdef LED_PIO_ARBITER_FLASH_EN
    test_flash_pairs(3'd2, 14'h3FFF, 2, 32'h0000_00F0, "flash2");
    test_flash_pairs(3'd0, 14'h1234, 1, 32'h0000_00F0, "flash0");
    test_reset_mid;
`else
    test_b_single;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
